// File: rtl/dispatch_stage_pkg.sv
// Shared definitions for the dispatch stage: ROB/register-file geometry,
// opcode constants and the opcode-to-class table used for destination and
// source selection.
package dispatch_stage_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned REG_CNT   = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned CNT_W     = 5;

  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_SUB = 6'h03;
  localparam logic [5:0] OP_AND = 6'h06;
  localparam logic [5:0] OP_OR  = 6'h07;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP
  } op_class_e;

  // Unlisted opcodes are treated as register-register ALU operations.
  function automatic op_class_e op_class(input logic [5:0] op);
    case (op)
      OP_LW:          return CLS_LOAD;
      OP_SW:          return CLS_STORE;
      OP_BEQ, OP_BNE: return CLS_BRANCH;
      OP_J:           return CLS_JUMP;
      default:        return CLS_ALU;
    endcase
  endfunction

  // Jumps read no register; loads use rt as their destination, not a source.
  function automatic logic uses_rs(input op_class_e c);
    return c != CLS_JUMP;
  endfunction

  function automatic logic uses_rt(input op_class_e c);
    return (c != CLS_JUMP) && (c != CLS_LOAD);
  endfunction

endpackage

// File: rtl/dispatch_stage_reg_status_table.sv
// Register status table: per architectural register a busy bit and the ROB
// tag of its latest in-flight producer.
//   rd1_*/rd2_*  combinational read ports (busy, tag)
//   wr_*         dispatch write: mark register busy with a new tag (r0 ignored)
//   clr_*        commit clear: release register if its tag still matches
//   flush        clear every busy bit (mispredict recovery)
module reg_status_table
  import dispatch_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rd1_addr,
  output logic             rd1_busy,
  output logic [TAG_W-1:0] rd1_tag,
  input  logic [REG_W-1:0] rd2_addr,
  output logic             rd2_busy,
  output logic [TAG_W-1:0] rd2_tag,
  input  logic             wr_en,
  input  logic [REG_W-1:0] wr_addr,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_addr,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic             flush
);

  logic [REG_CNT-1:0] busy;
  logic [TAG_W-1:0]   tags [REG_CNT];

  assign rd1_busy = busy[rd1_addr];
  assign rd1_tag  = tags[rd1_addr];
  assign rd2_busy = busy[rd2_addr];
  assign rd2_tag  = tags[rd2_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      for (int unsigned i = 0; i < REG_CNT; i++) tags[i] <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < REG_CNT; i++) begin
        // A dispatch to the same register shadows a same-cycle commit.
        if (wr_en && (wr_addr == REG_W'(i)) && (i != 0)) begin
          busy[i] <= 1'b1;
          tags[i] <= wr_tag;
        end else if (clr_en && (clr_addr == REG_W'(i)) && (tags[i] == clr_tag)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: decodes the fetched instruction, allocates a ROB tag,
// looks up operand producers in the register status table (with CDB bypass)
// and registers a dispatch packet. Stalls fetch when the ROB is full or the
// reservation stations are full.
//   clk, rst                 clock, asynchronous active-low reset
//   instr_IF_DP, pc_1_IF_DP  instruction (0 = bubble) and its PC+1
//   rs_full                  reservation stations cannot accept
//   cdb_valid/cdb_tag        completion broadcast
//   commit_valid/tag/rd      ROB head retirement
//   recover                  mispredict flush
//   dp_*                     registered dispatch packet
//   stall_IF_DP, stall_PC    combinational hold to fetch
module dispatch_stage
  import dispatch_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_IF_DP,
  input  logic [31:0]      pc_1_IF_DP,
  input  logic             rs_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [REG_W-1:0] commit_rd,
  input  logic             recover,
  output logic             dp_valid,
  output logic [5:0]       dp_opcode,
  output logic [TAG_W-1:0] dp_rob_tag,
  output logic [REG_W-1:0] dp_rd,
  output logic [15:0]      dp_imm,
  output logic [31:0]      dp_pc_1,
  output logic [TAG_W-1:0] dp_src1_tag,
  output logic [TAG_W-1:0] dp_src2_tag,
  output logic             dp_src1_rdy,
  output logic             dp_src2_rdy,
  output logic             stall_IF_DP,
  output logic             stall_PC
);

  logic [5:0]           opcode;
  logic [REG_W-1:0]     rs_a, rt_a, rd_f, dest;
  op_class_e            cls;
  logic                 bubble, stall, dispatch, commit_eff;
  logic [TAG_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic [ROB_DEPTH-1:0] done;
  logic                 rd1_busy, rd2_busy;
  logic [TAG_W-1:0]     rd1_tag, rd2_tag;
  logic [TAG_W-1:0]     src1_tag, src2_tag;
  logic                 src1_rdy, src2_rdy;

  assign opcode = instr_IF_DP[31:26];
  assign rs_a   = instr_IF_DP[25:21];
  assign rt_a   = instr_IF_DP[20:16];
  assign rd_f   = instr_IF_DP[15:11];
  assign cls    = op_class(opcode);

  always_comb begin
    dest = '0;
    case (cls)
      CLS_ALU:  dest = rd_f;
      CLS_LOAD: dest = rt_a;
      default:  dest = '0;
    endcase
  end

  assign bubble      = (instr_IF_DP == '0);
  assign stall       = rst && !bubble && ((count == CNT_W'(ROB_DEPTH)) || rs_full) && !recover;
  assign stall_IF_DP = stall;
  assign stall_PC    = stall;
  assign dispatch    = !bubble && !stall && !recover;
  assign commit_eff  = commit_valid && (count != '0);

  reg_status_table u_rst_tbl (
    .clk      (clk),
    .rst      (rst),
    .rd1_addr (rs_a),
    .rd1_busy (rd1_busy),
    .rd1_tag  (rd1_tag),
    .rd2_addr (rt_a),
    .rd2_busy (rd2_busy),
    .rd2_tag  (rd2_tag),
    .wr_en    (dispatch),
    .wr_addr  (dest),
    .wr_tag   (tail),
    .clr_en   (commit_eff),
    .clr_addr (commit_rd),
    .clr_tag  (commit_tag),
    .flush    (recover)
  );

  // Reads see the table before this instruction's own destination update.
  always_comb begin
    src1_tag = '0;
    src1_rdy = 1'b1;
    src2_tag = '0;
    src2_rdy = 1'b1;
    if (uses_rs(cls)) begin
      src1_tag = rd1_tag;
      src1_rdy = !rd1_busy || done[rd1_tag] || (cdb_valid && (cdb_tag == rd1_tag));
    end
    if (uses_rt(cls)) begin
      src2_tag = rd2_tag;
      src2_rdy = !rd2_busy || done[rd2_tag] || (cdb_valid && (cdb_tag == rd2_tag));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_valid    <= 1'b0;
      dp_opcode   <= '0;
      dp_rob_tag  <= '0;
      dp_rd       <= '0;
      dp_imm      <= '0;
      dp_pc_1     <= '0;
      dp_src1_tag <= '0;
      dp_src2_tag <= '0;
      dp_src1_rdy <= 1'b0;
      dp_src2_rdy <= 1'b0;
      done        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (recover) begin
      dp_valid <= 1'b0;
      done     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      dp_valid <= dispatch;
      if (dispatch) begin
        dp_opcode   <= opcode;
        dp_rob_tag  <= tail;
        dp_rd       <= dest;
        dp_imm      <= instr_IF_DP[15:0];
        dp_pc_1     <= pc_1_IF_DP;
        dp_src1_tag <= src1_tag;
        dp_src2_tag <= src2_tag;
        dp_src1_rdy <= src1_rdy;
        dp_src2_rdy <= src2_rdy;
        tail        <= tail + 1'b1;
      end
      // CDB set first so a tag re-allocated this cycle ends up not-done.
      if (cdb_valid) done[cdb_tag] <= 1'b1;
      if (dispatch)  done[tail]    <= 1'b0;
      case ({dispatch, commit_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
